cla_adder_32: RTL and testbench
===============================

Name: cla_adder_32

Overview:
- 32-bit two-level carry-lookahead adder/subtractor for the processor ALU; backs the ALU add and subtract operations.
- Computes A+B or A-B on signed two's-complement operands, with signed-overflow detection.
- Result and overflow are registered: one-cycle latency, one clock domain.

Parameters:
- None. Width is fixed at 32; lookahead block size is fixed at 8.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- A  input  32  operand A, signed two's complement.
- B  input  32  operand B, signed two's complement.
- ctrl_ALUopcode  input  5  operation select: 5'b00001 = subtract; every other value = add.
- S  output  32  registered sum/difference, signed.
- overflow  output  1  registered signed-overflow flag.

Behaviour:
- Reset: on a rising clock edge with reset=1, S <= 0 and overflow <= 0. Reset has priority over any operand or opcode activity in the same cycle.
- Operation select:
  - Add: Beff = B, cin = 0.
  - Subtract (opcode 5'b00001): Beff = ~B, cin = 1.
- Arithmetic: sum = A + Beff + cin, modulo 2^32; the carry out of bit 31 is discarded.
- Structure, level 1:
  - Per-bit g_i = A_i & Beff_i and p_i = A_i | Beff_i.
  - Four 8-bit lookahead blocks (bits 7:0, 15:8, 23:16, 31:24). Each block computes its internal carries from its own carry-in using flattened lookahead equations; no bit-to-bit ripple.
  - Each block also produces a block generate G and block propagate P.
- Structure, level 2:
  - Block carries c8, c16, c24, c32 come from cin and the block G/P by flattened lookahead; no block-to-block ripple.
  - c32 is the adder carry out.
- Overflow: overflow_next = (A[31] == Beff[31]) && (sum[31] != A[31]). Equivalently, c31 XOR c32.
- Datapath is purely combinational up to the output register.
- Latency: inputs sampled at rising edge N appear on S/overflow after edge N. Back-to-back operations are accepted every cycle.
- No handshake. Outputs hold their value until the next edge.
- Boundary cases:
  - 0x7FFFFFFF + 1 wraps to 0x80000000, overflow = 1.
  - 0x80000000 - 1 = 0x7FFFFFFF, overflow = 1.
  - 0x80000000 - 0x80000000 = 0, overflow = 0.
  - Unsigned carry out alone (e.g. -1 + 1) never sets overflow.
- Opcode change mid-stream: the output reflects the opcode sampled at the same edge as the operands.

Optional Feature:
- Macro: CLA_CARRY_OUT_EN.
- Defined:
  - Adds output port carry_out (1 bit), listed after overflow.
  - carry_out is the registered c32. For subtract it is the raw c32, i.e. the inverse borrow, not inverted.
  - carry_out resets to 0 and has the same latency as S.
- Undefined:
  - Port absent. c32 is used only internally for overflow; no other behaviour changes.

Test Plan:
- Reset: reset=1 for 2 cycles with A=5, B=7 -> S=0, overflow=0. Release reset; after the next edge S=12, overflow=0.
- Positive overflow: A=1073741824, B=1073741824, opcode 0 -> S=0x80000000 (-2147483648), overflow=1 one cycle later.
- Subtract: A=100, B=250, opcode 1 -> S=-150 (0xFFFFFF6A), overflow=0. Then A=0x80000000, B=1, opcode 1 -> S=0x7FFFFFFF, overflow=1.
- Carry chain: A=0xFFFFFFFF, B=1, opcode 0 -> S=0, overflow=0; with CLA_CARRY_OUT_EN, carry_out=1. Also A=0x00FFFFFF, B=1 -> S=0x01000000, exercising the c8/c16/c24 block carries.
- Back-to-back and opcode decode: apply (3+4, opcode 0), (3-4, opcode 1), (3 op 4, opcode 5'b00010) on consecutive cycles -> S = 7, -1, 7 on consecutive cycles.
- Random: 10,000 random A, B and opcode in {0,1} -> S matches the 32-bit reference sum/difference, and overflow matches the sign-rule model every cycle.

Source files
------------

// File: rtl/cla_adder_32.sv
// cla_adder_32 - 32-bit two-level carry-lookahead adder/subtractor for the ALU.
//
// Computes A + B, or A - B when ctrl_ALUopcode == 5'b00001. Result and
// signed-overflow flag are registered, giving one cycle of latency with a new
// operation accepted every cycle.
//
// Structure:
//   level 1 - four 8-bit lookahead blocks. Each block derives its internal
//             carries from its own carry-in with flattened sum-of-products
//             equations, and reports a block generate / block propagate.
//   level 2 - block carries c8/c16/c24/c32 derived from cin and the block
//             G/P terms, again flattened (no block-to-block ripple).
//
// Optional build macro:
//   CLA_CARRY_OUT_EN - adds a registered carry_out port carrying c32 (the raw
//                      carry, i.e. the inverse borrow on subtract).

module cla_adder_32 (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [4:0]  ctrl_ALUopcode,
    output logic [31:0] S,
    output logic        overflow
`ifdef CLA_CARRY_OUT_EN
    ,
    output logic        carry_out
`endif
);

    localparam logic [4:0] OP_SUB = 5'b00001;

    // Internal carries c[0..7] of one 8-bit block; c[0] is the block carry-in.
    // Each c[k] is built as an independent OR of product terms
    //   c[k] = g[k-1] | p[k-1]g[k-2] | ... | p[k-1]..p[0]cin
    // so no carry depends on a previously computed carry.
    function automatic logic [7:0] block_carries(input logic [7:0] g,
                                                 input logic [7:0] p,
                                                 input logic       cin);
        logic [7:0] c;
        logic       term;
        c    = '0;
        c[0] = cin;
        for (int k = 1; k < 8; k++) begin
            term = cin;
            for (int m = 0; m < k; m++) begin
                term = term & p[m];
            end
            c[k] = term;
            for (int j = 0; j < k; j++) begin
                term = g[j];
                for (int m = j + 1; m < k; m++) begin
                    term = term & p[m];
                end
                c[k] = c[k] | term;
            end
        end
        return c;
    endfunction

    // Block generate: the block produces a carry out regardless of its carry-in.
    function automatic logic block_generate(input logic [7:0] g,
                                            input logic [7:0] p);
        logic gen;
        logic term;
        gen = 1'b0;
        for (int j = 0; j < 8; j++) begin
            term = g[j];
            for (int m = j + 1; m < 8; m++) begin
                term = term & p[m];
            end
            gen = gen | term;
        end
        return gen;
    endfunction

    logic        sub_op;
    logic [31:0] b_eff;
    logic        cin;
    logic [31:0] g;
    logic [31:0] p;
    logic [3:0]  blk_g;
    logic [3:0]  blk_p;
    logic        c8;
    logic        c16;
    logic        c24;
    logic        c32;
    logic [31:0] carry;
    logic [31:0] sum;
    logic        ovf_next;

    // Operand conditioning: subtract is A + ~B + 1.
    always_comb begin
        sub_op = (ctrl_ALUopcode == OP_SUB);
        b_eff  = sub_op ? ~B : B;
        cin    = sub_op;
        g      = A & b_eff;
        p      = A | b_eff;
    end

    // Level 1: block generate and propagate for each 8-bit slice.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so
        // no path through the block can leave it unassigned and infer a latch.
        blk_g = '0;
        blk_p = '0;
        for (int b = 0; b < 4; b++) begin
            blk_g[b] = block_generate(g[b*8 +: 8], p[b*8 +: 8]);
            blk_p[b] = &p[b*8 +: 8];
        end
    end

    // Level 2: flattened block carries from cin and the block G/P terms.
    always_comb begin
        c8  = blk_g[0]
            | (blk_p[0] & cin);
        c16 = blk_g[1]
            | (blk_p[1] & blk_g[0])
            | (blk_p[1] & blk_p[0] & cin);
        c24 = blk_g[2]
            | (blk_p[2] & blk_g[1])
            | (blk_p[2] & blk_p[1] & blk_g[0])
            | (blk_p[2] & blk_p[1] & blk_p[0] & cin);
        c32 = blk_g[3]
            | (blk_p[3] & blk_g[2])
            | (blk_p[3] & blk_p[2] & blk_g[1])
            | (blk_p[3] & blk_p[2] & blk_p[1] & blk_g[0])
            | (blk_p[3] & blk_p[2] & blk_p[1] & blk_p[0] & cin);
    end

    // Per-bit carries inside each block, seeded by that block's carry-in.
    always_comb begin
        carry[7:0]   = block_carries(g[7:0],   p[7:0],   cin);
        carry[15:8]  = block_carries(g[15:8],  p[15:8],  c8);
        carry[23:16] = block_carries(g[23:16], p[23:16], c16);
        carry[31:24] = block_carries(g[31:24], p[31:24], c24);
    end

    // Sum bits and signed overflow (carry into the sign bit differs from
    // carry out of it).
    always_comb begin
        sum      = A ^ b_eff ^ carry;
        ovf_next = carry[31] ^ c32;
    end

    // Output register; synchronous reset wins over any new operation.
    always_ff @(posedge clock) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            S        <= '0;
            overflow <= 1'b0;
        end else begin
            S        <= sum;
            overflow <= ovf_next;
        end
    end

`ifdef CLA_CARRY_OUT_EN
    // Registered raw carry out of bit 31, aligned with S.
    always_ff @(posedge clock) begin
        if (reset) begin
            carry_out <= 1'b0;
        end else begin
            carry_out <= c32;
        end
    end
`endif

endmodule

// File: tb/tb_cla_adder_32.sv
// tb_cla_adder_32 - scoreboard bench for cla_adder_32.
// Stimulus pushes the expected result of each issued operation into a queue;
// a monitor pops and compares one entry per cycle in which a result is due.

module tb_cla_adder_32;

    logic        clock;
    logic        reset;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  ctrl_ALUopcode;
    logic [31:0] S;
    logic        overflow;
`ifdef CLA_CARRY_OUT_EN
    logic        carry_out;
`endif

    typedef struct {
        logic [31:0] s;
        logic        ov;
        logic        co;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    logic in_valid = 1'b0;
    logic pend = 1'b0;

    cla_adder_32 dut (
        .clock          (clock),
        .reset          (reset),
        .A              (A),
        .B              (B),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .S              (S),
        .overflow       (overflow)
`ifdef CLA_CARRY_OUT_EN
        ,
        .carry_out      (carry_out)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act_s,
                         input logic act_ov, input logic act_co, input exp_t e);
        logic bad;
        checks++;
        bad = (act_s !== e.s) || (act_ov !== e.ov);
`ifdef CLA_CARRY_OUT_EN
        bad = bad || (act_co !== e.co);
`endif
        if (bad) begin
            errors++;
            $display("FAIL %s: got S=%h ov=%b co=%b, want S=%h ov=%b co=%b",
                     name, act_s, act_ov, act_co, e.s, e.ov, e.co);
        end
    endtask

    // Drive one operation just after a rising edge; it is captured at the next.
    task automatic issue(input logic rst, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] op, input logic [31:0] es,
                         input logic eov, input logic eco, input string name);
        exp_t e;
        @(posedge clock);
        #1;
        reset          = rst;
        A              = a;
        B              = b;
        ctrl_ALUopcode = op;
        in_valid       = 1'b1;
        e.s = es; e.ov = eov; e.co = eco; e.name = name;
        sb.push_back(e);
    endtask

    // Reference model, written from the arithmetic definition.
    task automatic issue_model(input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] op, input string name);
        logic [32:0] wide;
        logic [31:0] s;
        logic        ov;
        if (op == 5'b00001) begin
            wide = {1'b0, a} - {1'b0, b};
            s    = wide[31:0];
            ov   = (a[31] != b[31]) && (s[31] != a[31]);
            issue(1'b0, a, b, op, s, ov, (a >= b), name);
        end else begin
            wide = {1'b0, a} + {1'b0, b};
            s    = wide[31:0];
            ov   = (a[31] == b[31]) && (s[31] != a[31]);
            issue(1'b0, a, b, op, s, ov, wide[32], name);
        end
    endtask

    // Monitor: a result is due one edge after an issued operation.
    always @(posedge clock) pend <= in_valid;

    always @(negedge clock) begin
        logic co;
        exp_t e;
`ifdef CLA_CARRY_OUT_EN
        co = carry_out;
`else
        co = 1'b0;
`endif
        if (pend) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got S=%h with no expected entry", S);
            end else begin
                e = sb.pop_front();
                check(e.name, S, overflow, co, e);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, want under 2000000", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [4:0]  rop;
        reset = 1'b1; A = '0; B = '0; ctrl_ALUopcode = '0;

        issue(1'b1, 32'd5, 32'd7, 5'd0, 32'd0, 1'b0, 1'b0, "reset_0");
        issue(1'b1, 32'd5, 32'd7, 5'd0, 32'd0, 1'b0, 1'b0, "reset_1");
        issue(1'b0, 32'd5, 32'd7, 5'd0, 32'd12, 1'b0, 1'b0, "after_reset_5p7");
        issue(1'b0, 32'h4000_0000, 32'h4000_0000, 5'd0, 32'h8000_0000, 1'b1, 1'b0, "pos_overflow");
        issue(1'b0, 32'd100, 32'd250, 5'd1, 32'hFFFF_FF6A, 1'b0, 1'b0, "sub_100m250");
        issue(1'b0, 32'h8000_0000, 32'd1, 5'd1, 32'h7FFF_FFFF, 1'b1, 1'b1, "min_minus_1");
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'h0000_0000, 1'b0, 1'b1, "neg1_plus_1");
        issue(1'b0, 32'h00FF_FFFF, 32'd1, 5'd0, 32'h0100_0000, 1'b0, 1'b0, "carry_c24");
        issue(1'b0, 32'h0000_FFFF, 32'd1, 5'd0, 32'h0001_0000, 1'b0, 1'b0, "carry_c16");
        issue(1'b0, 32'h7FFF_FFFF, 32'd1, 5'd0, 32'h8000_0000, 1'b1, 1'b0, "max_plus_1");
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd1, 32'h0000_0000, 1'b0, 1'b1, "min_minus_min");
        issue(1'b0, 32'd3, 32'd4, 5'd0, 32'd7, 1'b0, 1'b0, "b2b_add");
        issue(1'b0, 32'd3, 32'd4, 5'd1, 32'hFFFF_FFFF, 1'b0, 1'b0, "b2b_sub");
        issue(1'b0, 32'd3, 32'd4, 5'b00010, 32'd7, 1'b0, 1'b0, "b2b_op2_add");
        issue(1'b0, 32'd10, 32'd20, 5'b11111, 32'd30, 1'b0, 1'b0, "op1f_add");
        issue(1'b0, 32'd10, 32'd20, 5'b00011, 32'd30, 1'b0, 1'b0, "op3_add");
        issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1, 32'd0, 1'b0, 1'b0, "mid_reset");
        issue(1'b0, 32'h8000_0000, 32'h8000_0000, 5'd0, 32'h0000_0000, 1'b1, 1'b1, "neg_overflow");

        for (int i = 0; i < 10000; i++) begin
            ra  = $urandom;
            rb  = $urandom;
            rop = 5'($urandom_range(0, 1));
            issue_model(ra, rb, rop, "random");
        end

        @(posedge clock);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
